periph_bus_master: RTL and testbench

//  Initiator side of the peripheral register bus (addr/write_data/write_en/read_en/chipselect/read_data).

---
 rtl/periph_bus_pkg.sv | 22 ++
 rtl/periph_bus_master_addr_decode.sv | 22 ++
 rtl/periph_bus_master.sv | 161 ++++++++++++++++
 tb/tb_periph_bus_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// Shared types and address map for the peripheral register bus.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } bus_state_e;

    localparam int          DATA_W       = 16;
    localparam int          SLOT_FIELD_W = 6;
    localparam logic [15:0] PERIPH_BASE  = 16'hFF00;

    localparam int unsigned SLOT_TIMER   = 0;

    localparam logic [1:0]  TIMER_COUNT  = 2'd0;
    localparam logic [1:0]  TIMER_PERIOD = 2'd1;
    localparam logic [1:0]  TIMER_CTRL   = 2'd2;
    localparam logic [1:0]  TIMER_STATUS = 2'd3;

endpackage

// File: rtl/periph_bus_master_addr_decode.sv
// Splits a CPU word address into window hit, slot number and register index.
module periph_addr_decode
    import periph_bus_pkg::*;
#(
    parameter int          N_SLOTS   = 4,
    parameter logic [15:0] BASE_ADDR = PERIPH_BASE
) (
    input  logic [15:0]             cpu_addr_i,
    output logic                    hit_o,
    output logic [SLOT_FIELD_W-1:0] slot_o,
    output logic [1:0]              reg_o
);

    logic [SLOT_FIELD_W-1:0] slot_field;

    assign slot_field = cpu_addr_i[7:2];
    assign slot_o     = slot_field;
    assign reg_o      = cpu_addr_i[1:0];
    assign hit_o      = (cpu_addr_i[15:8] == BASE_ADDR[15:8]) &&
                        ({26'd0, slot_field} < 32'(N_SLOTS));

endmodule

// File: rtl/periph_bus_master.sv
// Single-request CPU-to-peripheral bus master with one-hot slot chipselects.
// state  | meaning
// IDLE   | ready for a CPU request
// ACCESS | one-cycle strobe with chipselect/addr/write_data on the bus
// WAIT   | load only: chipselect held while read data settles
// RESP   | one-cycle cpu_done (with cpu_err on a miss)
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter int          N_SLOTS      = 4,
    parameter logic [15:0] BASE_ADDR    = PERIPH_BASE,
    parameter int          READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [15:0]             cpu_addr_i,
    input  logic [15:0]             cpu_wdata_i,
    output logic                    cpu_ready_o,
    output logic                    cpu_done_o,
    output logic                    cpu_err_o,
    output logic [15:0]             cpu_rdata_o,
    output logic [1:0]              addr_o,
    output logic [15:0]             write_data_o,
    output logic                    write_en_o,
    output logic                    read_en_o,
    output logic [N_SLOTS-1:0]      chipselect_o,
    input  logic [16*N_SLOTS-1:0]   read_data_i
);

    bus_state_e              state_q;
    logic                    cpu_ready_q;
    logic                    cpu_done_q;
    logic                    cpu_err_q;
    logic [15:0]             cpu_rdata_q;
    logic [1:0]              addr_q;
    logic [15:0]             write_data_q;
    logic                    write_en_q;
    logic                    read_en_q;
    logic [N_SLOTS-1:0]      chipselect_q;
    logic [SLOT_FIELD_W-1:0] slot_q;
    logic                    we_q;
    logic [2:0]              wait_cnt_q;

    logic                    dec_hit;
    logic [SLOT_FIELD_W-1:0] dec_slot;
    logic [1:0]              dec_reg;
    logic [N_SLOTS-1:0]      cs_onehot;
    logic [15:0]             rd_slice;

    periph_addr_decode #(
        .N_SLOTS   (N_SLOTS),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .cpu_addr_i (cpu_addr_i),
        .hit_o      (dec_hit),
        .slot_o     (dec_slot),
        .reg_o      (dec_reg)
    );

    always_comb begin
        cs_onehot = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (dec_slot == SLOT_FIELD_W'(s)) cs_onehot[s] = 1'b1;
        end
    end

    always_comb begin
        rd_slice = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (slot_q == SLOT_FIELD_W'(s)) rd_slice = read_data_i[16*s +: 16];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            cpu_ready_q  <= 1'b1;
            cpu_done_q   <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            addr_q       <= '0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            chipselect_q <= '0;
            slot_q       <= '0;
            we_q         <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            // Strobes and completion are single-cycle pulses by construction.
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            cpu_done_q <= 1'b0;
            cpu_err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_req_i) begin
                        cpu_ready_q <= 1'b0;
                        cpu_rdata_q <= '0;
                        we_q        <= cpu_we_i;
                        slot_q      <= dec_slot;
                        if (dec_hit) begin
                            state_q      <= ACCESS;
                            chipselect_q <= cs_onehot;
                            addr_q       <= dec_reg;
                            write_data_q <= cpu_wdata_i;
                            write_en_q   <= cpu_we_i;
                            read_en_q    <= !cpu_we_i;
                        end else begin
                            state_q    <= RESP;
                            cpu_done_q <= 1'b1;
                            cpu_err_q  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state_q      <= RESP;
                        cpu_done_q   <= 1'b1;
                        chipselect_q <= '0;
                        addr_q       <= '0;
                        write_data_q <= '0;
                    end else begin
                        state_q    <= WAIT;
                        wait_cnt_q <= 3'(READ_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == 3'd0) begin
                        state_q      <= RESP;
                        cpu_done_q   <= 1'b1;
                        cpu_rdata_q  <= rd_slice;
                        chipselect_q <= '0;
                        addr_q       <= '0;
                        write_data_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    cpu_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ready_o  = cpu_ready_q;
    assign cpu_done_o   = cpu_done_q;
    assign cpu_err_o    = cpu_err_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign addr_o       = addr_q;
    assign write_data_o = write_data_q;
    assign write_en_o   = write_en_q;
    assign read_en_o    = read_en_q;
    assign chipselect_o = chipselect_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Scoreboard bench: Timer model on slot 0, RAM models on slots 1-3, reference memory map in arrays.
module tb_periph_bus_master;
    import periph_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ready, cpu_done, cpu_err;
    logic [15:0] cpu_rdata;
    logic [1:0]  addr;
    logic [15:0] write_data;
    logic        write_en, read_en;
    logic [3:0]  chipselect;
    logic [63:0] read_data;

    periph_bus_master #(.N_SLOTS(4), .BASE_ADDR(16'hFF00), .READ_LATENCY(1)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_ready_o(cpu_ready),
        .cpu_done_o(cpu_done), .cpu_err_o(cpu_err), .cpu_rdata_o(cpu_rdata),
        .addr_o(addr), .write_data_o(write_data), .write_en_o(write_en),
        .read_en_o(read_en), .chipselect_o(chipselect), .read_data_i(read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral models: slot 0 is a Timer, slots 1-3 are 4-word RAMs; read data one cycle after read_en.
    logic        slv_init = 1'b1;
    logic [15:0] ram [1:3][0:3];
    logic [15:0] t_count, t_period, t_ctrl;
    logic [15:0] rd_q [0:3];

    always @(posedge clk) begin
        if (slv_init) begin
            for (int s = 1; s < 4; s++) for (int r = 0; r < 4; r++) ram[s][r] <= '0;
            for (int s = 0; s < 4; s++) rd_q[s] <= '0;
            t_count <= '0; t_period <= '0; t_ctrl <= '0;
        end else begin
            if (t_ctrl[0]) t_count <= t_count + 16'd1;
            if (chipselect[0]) begin
                if (write_en) begin
                    case (addr)
                        TIMER_COUNT:  t_count  <= write_data;
                        TIMER_PERIOD: t_period <= write_data;
                        TIMER_CTRL:   t_ctrl   <= write_data;
                        default: ;
                    endcase
                end
                if (read_en) begin
                    case (addr)
                        TIMER_COUNT:  rd_q[0] <= t_count;
                        TIMER_PERIOD: rd_q[0] <= t_period;
                        TIMER_CTRL:   rd_q[0] <= t_ctrl;
                        default:      rd_q[0] <= {15'd0, t_ctrl[0]};
                    endcase
                end
            end
            for (int s = 1; s < 4; s++) begin
                if (chipselect[s] && write_en) ram[s][addr] <= write_data;
                if (chipselect[s] && read_en)  rd_q[s] <= ram[s][addr];
            end
        end
    end
    assign read_data = {rd_q[3], rd_q[2], rd_q[1], rd_q[0]};

    typedef struct { bit err; bit is_load; int rdata; int cyc; } resp_t;
    typedef struct { bit we; int cs; int addr; int wdata; int cyc; } bus_t;
    resp_t rq[$];
    bus_t  bq[$];
    int    done_log[$];

    // Reference memory map: ref_mem[slot][reg]; Timer STATUS reads CTRL bit 0, COUNT is never checked.
    int ref_mem [0:3][0:3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (cpu_done) begin
                if (rq.size() == 0) fail_now("done_unexpected");
                else begin
                    resp_t r;
                    r = rq.pop_front();
                    check("done_cycle", cyc, r.cyc);
                    check("cpu_err", int'(cpu_err), int'(r.err));
                    if (r.err || r.is_load) check("cpu_rdata", int'(cpu_rdata), r.rdata);
                    if (r.err) check("miss_no_cs", int'(chipselect), 0);
                    done_log.push_back(cyc);
                end
            end
            if (write_en || read_en) begin
                if (bq.size() == 0) fail_now("strobe_unexpected");
                else begin
                    bus_t b;
                    b = bq.pop_front();
                    check("bus_cycle", cyc, b.cyc);
                    check("write_en", int'(write_en), int'(b.we));
                    check("read_en", int'(read_en), int'(!b.we));
                    check("chipselect", int'(chipselect), b.cs);
                    check("bus_addr", int'(addr), b.addr);
                    if (b.we) check("write_data", int'(write_data), b.wdata);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic issue(input bit we, input logic [15:0] a, input logic [15:0] d, input bit expect_done);
        int n, acc, slot, rg;
        bit hit;
        resp_t r;
        bus_t b;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        n = 0;
        while (!cpu_ready && n < 50) begin @(negedge clk); n++; end
        if (!cpu_ready) begin
            fail_now("ready_timeout");
            cpu_req = 1'b0;
            return;
        end
        acc  = cyc + 1;
        hit  = (int'(a) >= 'hFF00) && (int'(a) < 'hFF00 + 4 * 4);
        slot = (int'(a) - 'hFF00) / 4;
        rg   = int'(a) % 4;
        r.err = !hit; r.is_load = !we; r.rdata = 0;
        if (!hit) r.cyc = acc;
        else begin
            r.cyc   = we ? acc + 1 : acc + 2;
            b.we    = we; b.cs = 1 << slot; b.addr = rg; b.wdata = int'(d); b.cyc = acc;
            bq.push_back(b);
            if (we) begin
                if (!(slot == 0 && rg == 3)) ref_mem[slot][rg] = int'(d);
            end else begin
                r.rdata = (slot == 0 && rg == 3) ? (ref_mem[0][2] & 1) : ref_mem[slot][rg];
            end
        end
        if (expect_done) rq.push_back(r);
        @(negedge clk);
        cpu_req = 1'b0;
        check("ready_drop", int'(cpu_ready), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 40) begin @(negedge clk); n++; end
        check("drain_resp_q", rq.size(), 0);
        check("drain_bus_q", bq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, kind, slot, rg, g;
        logic [15:0] a;
        for (int s = 0; s < 4; s++) for (int r = 0; r < 4; r++) ref_mem[s][r] = 0;

        repeat (3) @(negedge clk);
        slv_init = 1'b0;
        check("rst_ready", int'(cpu_ready), 1);
        check("rst_done", int'(cpu_done), 0);
        check("rst_err", int'(cpu_err), 0);
        check("rst_rdata", int'(cpu_rdata), 0);
        check("rst_bus", int'({addr, write_data, write_en, read_en, chipselect}), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Store then load Timer PERIOD; check chipselect/addr held through WAIT.
        issue(1'b1, 16'hFF01, 16'h0055, 1'b1);
        drain();
        issue(1'b0, 16'hFF01, 16'h0000, 1'b1);
        @(negedge clk);
        check("wait_cs_held", int'(chipselect), 1);
        check("wait_addr_held", int'(addr), 1);
        check("wait_no_strobe", int'({write_en, read_en}), 0);
        drain();

        // Start the Timer and poll STATUS.
        issue(1'b1, 16'hFF02, 16'h0101, 1'b1);
        for (int i = 0; i < 3; i++) issue(1'b0, 16'hFF03, 16'h0000, 1'b1);
        drain();

        // Unmapped accesses.
        issue(1'b0, 16'hFF14, 16'h0000, 1'b1);
        issue(1'b1, 16'hFF14, 16'hBEEF, 1'b1);
        issue(1'b0, 16'h1234, 16'h0000, 1'b1);
        drain();

        // Back-to-back loads with cpu_req held high.
        issue(1'b1, 16'hFF05, 16'hA1A1, 1'b1);
        issue(1'b1, 16'hFF0A, 16'hB2B2, 1'b1);
        issue(1'b1, 16'hFF0F, 16'hC3C3, 1'b1);
        drain();
        repeat (2) @(negedge clk);
        base = done_log.size();
        issue(1'b0, 16'hFF05, 16'h0000, 1'b1);
        issue(1'b0, 16'hFF0A, 16'h0000, 1'b1);
        issue(1'b0, 16'hFF0F, 16'h0000, 1'b1);
        drain();
        if (done_log.size() == base + 3) begin
            check("b2b_spacing_1", done_log[base+1] - done_log[base], 4);
            check("b2b_spacing_2", done_log[base+2] - done_log[base+1], 4);
        end else fail_now("b2b_done_count");

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                slot = $urandom_range(1, 3); rg = $urandom_range(0, 3);
                a = 16'hFF00 + 16'(slot * 4 + rg);
            end else if (kind <= 7) begin
                rg = $urandom_range(1, 3);
                a = 16'hFF00 + 16'(rg);
            end else if (kind == 8) begin
                slot = $urandom_range(4, 63); rg = $urandom_range(0, 3);
                a = 16'hFF00 + 16'(slot * 4 + rg);
            end else begin
                a = 16'($urandom_range(0, 254) * 256 + $urandom_range(0, 255));
            end
            issue(1'($urandom_range(0, 1)), a, 16'($urandom), 1'b1);
            g = $urandom_range(0, 2);
            repeat (g) @(negedge clk);
        end
        drain();

        // Reset during WAIT aborts the load; the next request completes normally.
        issue(1'b0, 16'hFF0A, 16'h0000, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_cs", int'(chipselect), 0);
        check("abort_ready", int'(cpu_ready), 1);
        check("abort_done", int'(cpu_done), 0);
        check("abort_strobes", int'({write_en, read_en}), 0);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", int'(cpu_done), 0);
        end
        issue(1'b0, 16'hFF0A, 16'h0000, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
